// File: rtl/recarb_pkg.sv
// recarbitbank shared types: default sizes, pending-entry struct, helpers.
// Optional lock mode is enabled with RECARB_LOCK_EN.
package recarb_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHANNELS = 4;
  localparam int DEF_AW = $clog2(DEF_CHANNELS);

  typedef struct packed {
    logic valid;
    logic [DEF_AW-1:0] ch;
    logic [DEF_WIDTH-1:0] data;
  } pend_t;

  function automatic logic in_range(
    input int unsigned a,
    input int unsigned n
  );
    return a < n;
  endfunction

endpackage

// File: rtl/recarb_if.sv
// recarbitbank bus: CPU access, LLC capture and status flags.
// Lock input lives on the top module under RECARB_LOCK_EN.
interface recarb_if
  import recarb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);
  localparam int AW = $clog2(CHANNELS);

  logic cpu_we;
  logic cpu_re;
  logic [AW-1:0] cpu_addr;
  logic [WIDTH-1:0] cpu_wdata;
  logic [WIDTH-1:0] cpu_rdata;
  logic can_we;
  logic [AW-1:0] can_ch;
  logic [WIDTH-1:0] recidin;
  logic [CHANNELS-1:0] new_flags;
  logic [CHANNELS-1:0] ovr_flags;
  logic pend_busy;

  modport master (
    output cpu_we, cpu_re, cpu_addr, cpu_wdata,
    output can_we, can_ch, recidin,
    input cpu_rdata, new_flags, ovr_flags, pend_busy
  );

  modport slave (
    input cpu_we, cpu_re, cpu_addr, cpu_wdata,
    input can_we, can_ch, recidin,
    output cpu_rdata, new_flags, ovr_flags, pend_busy
  );

endinterface

// File: rtl/recarb_pending.sv
// One-entry pending buffer for captures that lost to a CPU write.
// Same behaviour with or without RECARB_LOCK_EN.
module recarb_pending #(
  parameter int WIDTH = 16,
  parameter int AW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic cw,
  input  logic [AW-1:0] cpu_addr,
  input  logic cv,
  input  logic coll,
  input  logic [AW-1:0] can_ch,
  input  logic [WIDTH-1:0] recidin,
  output logic cmt,
  output logic [AW-1:0] cmt_ch,
  output logic [WIDTH-1:0] cmt_data,
  output logic park,
  output logic drop,
  output logic [AW-1:0] drop_ch,
  output logic busy
);

  typedef struct packed {
    logic valid;
    logic [AW-1:0] ch;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t ent;
  logic blocked;

  assign blocked = ent.valid && cw
                && cpu_addr == ent.ch;
  assign cmt = ent.valid && !blocked;
  assign drop = blocked && cv;
  // any capture arriving while blocked replaces the entry
  assign park = coll || drop;
  assign cmt_ch = ent.ch;
  assign cmt_data = ent.data;
  assign drop_ch = ent.ch;
  assign busy = ent.valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ent <= '0;
    end else if (park) begin
      ent <= '{valid: 1'b1, ch: can_ch, data: recidin};
    end else if (cmt) begin
      ent.valid <= 1'b0;
    end
  end

endmodule

// File: rtl/recarbitbank.sv
// Receive-arbitration register bank: CPU writes win, LLC captures park.
// Define RECARB_LOCK_EN to add the lock port (drop captures on unread data).
module recarbitbank
  import recarb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input logic clk,
  input logic rst,
`ifdef RECARB_LOCK_EN
  input logic lock,
`endif
  recarb_if.slave bus
);

  localparam int AW = $clog2(CHANNELS);

  logic [WIDTH-1:0] regs [CHANNELS];
  logic [WIDTH-1:0] regs_d [CHANNELS];
  logic [CHANNELS-1:0] new_q, new_d;
  logic [CHANNELS-1:0] ovr_q, ovr_d;
  logic [CHANNELS-1:0] held;
  logic [WIDTH-1:0] rdata_q;
  logic cw, cr, cv, coll, lk, direct;
  logic cmt, park, drop, busy;
  logic [AW-1:0] cmt_ch, drop_ch;
  logic [WIDTH-1:0] cmt_data;
  logic [1:0] src_v;
  logic [1:0][AW-1:0] src_ch;
  logic [1:0][WIDTH-1:0] src_d;

`ifdef RECARB_LOCK_EN
  assign lk = lock;
`else
  assign lk = 1'b0;
`endif

  assign cw = bus.cpu_we
           && in_range(32'(bus.cpu_addr), CHANNELS);
  assign cr = bus.cpu_re
           && in_range(32'(bus.cpu_addr), CHANNELS);
  assign cv = bus.can_we
           && in_range(32'(bus.can_ch), CHANNELS);
  assign coll = cw && cv
             && bus.cpu_addr == bus.can_ch;
  assign direct = cv && !park;

  recarb_pending #(
    .WIDTH(WIDTH),
    .AW(AW)
  ) u_pend (
    .clk(clk),
    .rst(rst),
    .cw(cw),
    .cpu_addr(bus.cpu_addr),
    .cv(cv),
    .coll(coll),
    .can_ch(bus.can_ch),
    .recidin(bus.recidin),
    .cmt(cmt),
    .cmt_ch(cmt_ch),
    .cmt_data(cmt_data),
    .park(park),
    .drop(drop),
    .drop_ch(drop_ch),
    .busy(busy)
  );

  // slot 0 is the pending commit, slot 1 the direct capture
  assign src_v = {direct, cmt};
  assign src_ch = {bus.can_ch, cmt_ch};
  assign src_d = {bus.recidin, cmt_data};

  always_comb begin
    regs_d = regs;
    new_d = new_q;
    ovr_d = ovr_q;
    held = new_q;
    if (cr) begin
      new_d[bus.cpu_addr] = 1'b0;
      ovr_d[bus.cpu_addr] = 1'b0;
    end
    if (cw) regs_d[bus.cpu_addr] = bus.cpu_wdata;
    if (drop) ovr_d[drop_ch] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      if (src_v[i]) begin
        if (held[src_ch[i]]) ovr_d[src_ch[i]] = 1'b1;
        if (!(lk && held[src_ch[i]]))
          regs_d[src_ch[i]] = src_d[i];
        new_d[src_ch[i]] = 1'b1;
        held[src_ch[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      regs <= '{default: '0};
      new_q <= '0;
      ovr_q <= '0;
      rdata_q <= '0;
    end else begin
      regs <= regs_d;
      new_q <= new_d;
      ovr_q <= ovr_d;
      if (bus.cpu_re)
        rdata_q <= cr ? regs[bus.cpu_addr] : '0;
    end
  end

  assign bus.cpu_rdata = rdata_q;
  assign bus.new_flags = new_q;
  assign bus.ovr_flags = ovr_q;
  assign bus.pend_busy = busy;

endmodule

// File: tb/tb_recarbitbank.sv
// Bench for recarbitbank: directed scenarios plus random traffic vs a model.
// Build with RECARB_LOCK_EN to exercise lock mode.
module tb_recarbitbank;
  import recarb_pkg::*;

  localparam int W = DEF_WIDTH;
  localparam int CH = DEF_CHANNELS;
  localparam int AW = $clog2(CH);
`ifdef RECARB_LOCK_EN
  localparam bit LOCK_BUILD = 1'b1;
`else
  localparam bit LOCK_BUILD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lock = 1'b0;

  recarb_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  recarbitbank #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk(clk),
    .rst(rst),
`ifdef RECARB_LOCK_EN
    .lock(lock),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [W-1:0] m_reg [CH];
  logic [CH-1:0] m_new, m_ovr;
  logic [W-1:0] m_rd;
  pend_t m_p;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t",
               tag, got, want, $time);
    end
  endtask

  // reference: apply this edge's events in rule order
  task automatic model_edge();
    pend_t q[$];
    pend_t np;
    logic [CH-1:0] nn, no, held;
    bit cw, cv, blk, lk;
    int a, c;
    if (!rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_new = '0;
      m_ovr = '0;
      m_rd = '0;
      m_p = '0;
      return;
    end
    a = int'(bus.cpu_addr);
    c = int'(bus.can_ch);
    lk = LOCK_BUILD && lock;
    cw = bus.cpu_we && a < CH;
    cv = bus.can_we && c < CH;
    held = m_new;
    nn = m_new;
    no = m_ovr;
    if (bus.cpu_re) begin
      m_rd = (a < CH) ? m_reg[a] : '0;
      if (a < CH) begin
        nn[a] = 1'b0;
        no[a] = 1'b0;
      end
    end
    if (cw) m_reg[a] = bus.cpu_wdata;
    blk = m_p.valid && cw && int'(m_p.ch) == a;
    np = m_p;
    if (m_p.valid && !blk) begin
      q.push_back(m_p);
      np.valid = 1'b0;
    end
    if (cv) begin
      if (blk) begin
        no[m_p.ch] = 1'b1;
        np = '{1'b1, bus.can_ch, bus.recidin};
      end else if (cw && c == a) begin
        np = '{1'b1, bus.can_ch, bus.recidin};
      end else begin
        q.push_back('{1'b1, bus.can_ch, bus.recidin});
      end
    end
    foreach (q[i]) begin
      if (held[q[i].ch]) no[q[i].ch] = 1'b1;
      if (!(lk && held[q[i].ch]))
        m_reg[q[i].ch] = q[i].data;
      nn[q[i].ch] = 1'b1;
      held[q[i].ch] = 1'b1;
    end
    m_new = nn;
    m_ovr = no;
    m_p = np;
  endtask

  task automatic step(input bit we, input bit re,
                      input int a, input logic [W-1:0] wd,
                      input bit ce, input int c,
                      input logic [W-1:0] d);
    bus.cpu_we = we;
    bus.cpu_re = re;
    bus.cpu_addr = AW'(a);
    bus.cpu_wdata = wd;
    bus.can_we = ce;
    bus.can_ch = AW'(c);
    bus.recidin = d;
    @(posedge clk);
    model_edge();
    #1;
    check("rdata", 32'(bus.cpu_rdata), 32'(m_rd));
    check("new", 32'(bus.new_flags), 32'(m_new));
    check("ovr", 32'(bus.ovr_flags), 32'(m_ovr));
    check("busy", 32'(bus.pend_busy), 32'(m_p.valid));
  endtask

  task automatic idle();
    step(0, 0, 0, '0, 0, 0, '0);
  endtask

  task automatic rd(input int a);
    step(0, 1, a, '0, 0, 0, '0);
  endtask

  initial begin
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wdata = '0;
    bus.can_we = 1'b0;
    bus.can_ch = '0;
    bus.recidin = '0;
    rst = 1'b0;
    idle();
    idle();
    rst = 1'b1;

    // reset clears prior writes
    step(1, 0, 1, 16'h1234, 0, 0, '0);
    rd(1);
    check("wr_ch1", 32'(bus.cpu_rdata), 32'h1234);
    rst = 1'b0;
    idle();
    rst = 1'b1;
    for (int i = 0; i < CH; i++) begin
      rd(i);
      check("rst_rd", 32'(bus.cpu_rdata), 32'h0);
    end
    check("rst_new", 32'(bus.new_flags), 32'h0);
    check("rst_busy", 32'(bus.pend_busy), 32'h0);

    // plain capture then read
    step(0, 0, 0, '0, 1, 2, 16'h0ABC);
    check("cap_new2", 32'(bus.new_flags[2]), 32'h1);
    rd(2);
    check("cap_rd2", 32'(bus.cpu_rdata), 32'h0ABC);
    check("cap_clr2", 32'(bus.new_flags[2]), 32'h0);

    // collision on ch0
    step(1, 0, 0, 16'h1111, 1, 0, 16'h2222);
    check("col_busy", 32'(bus.pend_busy), 32'h1);
    rd(0);
    check("col_cpu", 32'(bus.cpu_rdata), 32'h1111);
    check("col_new0", 32'(bus.new_flags[0]), 32'h1);
    check("col_done", 32'(bus.pend_busy), 32'h0);
    rd(0);
    check("col_cap", 32'(bus.cpu_rdata), 32'h2222);

    // blocked pending entry replaced by a ch1 capture
    step(1, 0, 3, 16'hAAAA, 1, 3, 16'h3333);
    step(1, 0, 3, 16'hBBBB, 0, 0, '0);
    check("blk_busy", 32'(bus.pend_busy), 32'h1);
    step(1, 0, 3, 16'hCCCC, 1, 1, 16'h0055);
    check("drop_ovr3", 32'(bus.ovr_flags[3]), 32'h1);
    idle();
    rd(1);
    check("repl_ch1", 32'(bus.cpu_rdata), 32'h0055);

    // double capture without a read
    lock = 1'b1;
    step(0, 0, 0, '0, 1, 1, 16'h0001);
    step(0, 0, 0, '0, 1, 1, 16'h0002);
    check("dbl_ovr1", 32'(bus.ovr_flags[1]), 32'h1);
    lock = 1'b0;
    rd(1);
    check("dbl_ch1", 32'(bus.cpu_rdata),
          LOCK_BUILD ? 32'h0001 : 32'h0002);

    // read racing a capture on ch2
    step(0, 1, 2, '0, 1, 2, 16'h0777);
    check("race_rd", 32'(bus.cpu_rdata), 32'h0ABC);
    check("race_new", 32'(bus.new_flags[2]), 32'h1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      lock = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 299) != 0);
      step($urandom_range(0, 9) < 4,
           $urandom_range(0, 9) < 4,
           int'($urandom_range(0, CH - 1)),
           W'($urandom),
           $urandom_range(0, 9) < 5,
           int'($urandom_range(0, CH - 1)),
           W'($urandom));
    end
    rst = 1'b1;
    lock = 1'b0;
    idle();
    idle();
    for (int i = 0; i < CH; i++) rd(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
